issue_queue_mw: RTL and testbench
=================================

ISSUE_QUEUE_MW -- requirements
Module: issue_queue_mw

Interface
REQ-001 SHALL have parameter DEPTH_P, default 16: number of queue entries, power of two, 4..32.
REQ-002 SHALL have parameter NUM_FU_P, default 4: number of functional units, each with its own issue port.
REQ-003 SHALL have parameter NUM_CDB_P, default 4: number of CDB broadcast channels.
REQ-004 SHALL have ports:
- clk_i  in  1  clock; all state on its rising edge.
- reset_ni  in  1  asynchronous, active-low reset.
- instr_i  in  renamed_instruction_t  dispatched instruction.
- src1_v_i, src2_v_i  in  1 each  operand valid from the register file in the dispatch cycle.
- src1_data_i, src2_data_i  in  WORD_SIZE_P each  operand data from the register file.
- in_valid_i / in_ready_o  in / out  1 each  dispatch handshake.
- issue_o[NUM_FU_P]  out  issued_instruction_t  per-FU instruction.
- issue_valid_o / issue_ready_i  out / in  NUM_FU_P each  per-FU issue handshake.
- cdb_i[NUM_CDB_P]  in  CDB_t  tag/result broadcast.
- st_clear_i  in  DEPTH_P  per-entry store-wait release.
- entry_sb_o  out  DEPTH_P x $clog2(SB_ENTRY)  per-entry store-buffer index.
- flush_i  in  1  discard all entries.
- count_o  out  $clog2(DEPTH_P)+1  occupied entries.

Function
REQ-005 Each entry SHALL hold one state: FREE, WAIT or READY.
REQ-006 Entry state SHALL change as follows:
- FREE->WAIT on accepted dispatch.
- WAIT->READY when src1, src2 and store gate are all valid.
- READY->FREE on an issue handshake.
- Any state->FREE on flush_i.
REQ-007 Dispatch SHALL be accepted when in_valid_i & in_ready_o & ~flush_i; the instruction goes into the lowest-index FREE entry.
REQ-008 in_ready_o SHALL equal (count != DEPTH_P), taken from the registered count only; space freed by a same-cycle issue is not counted.
REQ-009 At dispatch, a source SHALL be marked valid if it is an immediate, or if the register file reports it valid.
REQ-010 The store gate SHALL start valid unless instr_i.is_wfs; st_clear_i[e]=1 SHALL set it.
REQ-011 CDB wakeup: an entry with an invalid source SHALL capture the result of the lowest-index cdb_i channel whose dest tag matches; the source becomes valid in the next cycle.
REQ-012 Selection per FU f: issue_valid_o[f] SHALL be asserted for the oldest READY entry whose func_unit==f, ordered by dispatch sequence.
REQ-013 Selection SHALL be independent across FUs, allowing up to NUM_FU_P issues per cycle.
REQ-014 issue_o[f] SHALL stay stable while issue_valid_o[f] & ~issue_ready_i[f].
REQ-015 The earliest issue SHALL be the cycle after dispatch or the cycle after wakeup; there is no same-cycle dispatch-to-issue.
REQ-016 count SHALL update as count + accepted - (number of issue handshakes); it SHALL never wrap.
REQ-017 Dispatch sequence tags SHALL be $clog2(DEPTH_P)+1 bits and compared modulo 2^width; age order SHALL stay correct across tag wrap-around.
REQ-018 flush_i SHALL force issue_valid_o=0 and block dispatch in that cycle; the next cycle SHALL show count=0, in_ready_o=1 and all entries FREE.
REQ-019 A CDB match and an issue in the same cycle on one entry SHALL issue first; the capture is dropped.

Reset
REQ-020 While reset_ni=0, asynchronously and regardless of clock, all entries SHALL be FREE, count_o=0, in_ready_o=0, issue_valid_o=0 and entry_sb_o=0.
REQ-021 In-flight entries at reset SHALL be discarded.
REQ-022 in_ready_o SHALL rise on the first clock edge after reset_ni deasserts.

Configuration
REQ-023 With ISSUE_DISPATCH_BYPASS_EN defined, the dispatch cycle's operands SHALL also be compared against cdb_i; a match marks the source valid at allocation and captures its data.
REQ-024 Without ISSUE_DISPATCH_BYPASS_EN, a result broadcast only in the dispatch cycle SHALL be missed; the register file supplies it.

Structure
REQ-025 renamed_instruction_t, issued_instruction_t, CDB_t, WORD_SIZE_P, SB_ENTRY and NUM_PHYS_REG SHALL come from Purple_Jade_pkg.
REQ-026 A new iq_entry_state_e enum SHALL be added to Purple_Jade_pkg.
REQ-027 One sub-module, iq_age_select, SHALL be instantiated per FU: inputs are the request vector and sequence tags; outputs are a one-hot grant and a valid.

Verification
REQ-028 Dispatch ALU op, both sources valid, at cycle 0 -> issue_valid_o[ALU]=1 at cycle 1; count 1 -> 0 after the handshake.
REQ-029 Fill 16 entries with src1 waiting on tag 7, then broadcast tag 7 with 0xBEEF -> oldest entry per FU issues first with src1_data=0xBEEF; in_ready_o=0 while full.
REQ-030 Hold issue_ready_i[0]=0 for 3 cycles -> issue_o[0] unchanged; the other FUs still issue.
REQ-031 is_wfs entry with operands valid -> no issue until st_clear_i[e]=1, then issue on the following cycle.
REQ-032 Assert flush_i with 5 entries, or drop reset_ni mid-stream -> no issue_valid_o that cycle; count_o=0 next cycle or immediately, respectively.
REQ-033 Broadcast tag 3 in the same cycle as dispatching a consumer of tag 3 -> consumer issues at cycle 1 with the bypass macro; without it the consumer stays WAIT.

Source files
------------

// File: rtl/Purple_Jade_pkg.sv
// Shared core types: renamed/issued instruction bundles, CDB, issue queue.
// ISSUE_DISPATCH_BYPASS_EN is consumed by issue_queue_mw.
package Purple_Jade_pkg;

  localparam int WORD_SIZE_P  = 32;
  localparam int SB_ENTRY     = 8;
  localparam int NUM_PHYS_REG = 64;
  localparam int SB_W   = $clog2(SB_ENTRY);
  localparam int PREG_W = $clog2(NUM_PHYS_REG);
  localparam int FU_W   = 2;
  localparam int OP_W   = 8;

  typedef enum logic [1:0] {
    IQ_FREE  = 2'd0,
    IQ_WAIT  = 2'd1,
    IQ_READY = 2'd2
  } iq_entry_state_e;

  typedef struct packed {
    logic [OP_W-1:0]        op;
    logic [PREG_W-1:0]      dest;
    logic [PREG_W-1:0]      src1;
    logic [PREG_W-1:0]      src2;
    logic                   src1_is_imm;
    logic                   src2_is_imm;
    logic [WORD_SIZE_P-1:0] imm;
    logic [FU_W-1:0]        func_unit;
    logic                   is_wfs;
    logic [SB_W-1:0]        sb_idx;
  } renamed_instruction_t;

  typedef struct packed {
    logic [OP_W-1:0]        op;
    logic [PREG_W-1:0]      dest;
    logic [WORD_SIZE_P-1:0] src1_data;
    logic [WORD_SIZE_P-1:0] src2_data;
    logic [SB_W-1:0]        sb_idx;
  } issued_instruction_t;

  typedef struct packed {
    logic                   valid;
    logic [PREG_W-1:0]      tag;
    logic [WORD_SIZE_P-1:0] data;
  } CDB_t;

  typedef struct packed {
    logic [OP_W-1:0]   op;
    logic [PREG_W-1:0] dest;
    logic [PREG_W-1:0] src1;
    logic [PREG_W-1:0] src2;
    logic [FU_W-1:0]   func_unit;
    logic [SB_W-1:0]   sb_idx;
  } iq_meta_t;

endpackage

// File: rtl/iq_age_select.sv
// Oldest-request picker over wrap-around dispatch sequence tags.
// Tags of live entries span less than half the tag space.
module iq_age_select #(
  parameter int N     = 16,
  parameter int SEQ_W = 5
) (
  input  logic [N-1:0]     req_i,
  input  logic [SEQ_W-1:0] seq_i [N],
  output logic [N-1:0]     grant_o,
  output logic             valid_o
);

  function automatic logic older(
    input logic [SEQ_W-1:0] a,
    input logic [SEQ_W-1:0] b
  );
    return 1'((a - b) >> (SEQ_W - 1));
  endfunction

  logic win;

  always_comb begin
    grant_o = '0;
    win     = 1'b0;
    for (int i = 0; i < N; i++) begin
      win = req_i[i];
      for (int j = 0; j < N; j++) begin
        if (j != i && req_i[j] &&
            !older(seq_i[i], seq_i[j]))
          win = 1'b0;
      end
      grant_o[i] = win;
    end
    valid_o = |req_i;
  end

endmodule

// File: rtl/issue_queue_mw.sv
// Multi-wakeup issue queue with per-FU oldest-first selection.
// Define ISSUE_DISPATCH_BYPASS_EN to snoop the CDB at dispatch.
module issue_queue_mw
  import Purple_Jade_pkg::*;
#(
  parameter int DEPTH_P   = 16,
  parameter int NUM_FU_P  = 4,
  parameter int NUM_CDB_P = 4
) (
  input  logic                    clk_i,
  input  logic                    reset_ni,
  input  renamed_instruction_t    instr_i,
  input  logic                    src1_v_i,
  input  logic                    src2_v_i,
  input  logic [WORD_SIZE_P-1:0]  src1_data_i,
  input  logic [WORD_SIZE_P-1:0]  src2_data_i,
  input  logic                    in_valid_i,
  output logic                    in_ready_o,
  output issued_instruction_t     issue_o [NUM_FU_P],
  output logic [NUM_FU_P-1:0]     issue_valid_o,
  input  logic [NUM_FU_P-1:0]     issue_ready_i,
  input  CDB_t                    cdb_i [NUM_CDB_P],
  input  logic [DEPTH_P-1:0]      st_clear_i,
  output logic [SB_W-1:0]         entry_sb_o [DEPTH_P],
  input  logic                    flush_i,
  output logic [$clog2(DEPTH_P):0] count_o
);

  localparam int IDX_W = $clog2(DEPTH_P);
  localparam int SEQ_W = IDX_W + 1;

`ifdef ISSUE_DISPATCH_BYPASS_EN
  localparam bit BYPASS_EN = 1'b1;
`else
  localparam bit BYPASS_EN = 1'b0;
`endif

  iq_entry_state_e        state_q [DEPTH_P];
  iq_meta_t               meta_q  [DEPTH_P];
  logic [DEPTH_P-1:0]     s1v_q, s2v_q, stv_q;
  logic [WORD_SIZE_P-1:0] s1d_q   [DEPTH_P];
  logic [WORD_SIZE_P-1:0] s2d_q   [DEPTH_P];
  logic [SEQ_W-1:0]       seq_q   [DEPTH_P];
  logic [SEQ_W-1:0]       seq_ctr_q;
  logic [IDX_W:0]         cnt_q;
  logic                   rdy_en_q;
  logic [NUM_FU_P-1:0]    lock_q;
  logic [IDX_W-1:0]       lock_idx_q [NUM_FU_P];

  logic                   accept;
  logic [IDX_W-1:0]       alloc_idx;
  logic                   d_s1v, d_s2v, d_stv;
  logic [WORD_SIZE_P-1:0] d_s1d, d_s2d;
  iq_meta_t               d_meta;

  logic [DEPTH_P-1:0]     cap1, cap2, n1v, n2v, nstv;
  logic [WORD_SIZE_P-1:0] cap1_d [DEPTH_P];
  logic [WORD_SIZE_P-1:0] cap2_d [DEPTH_P];

  logic [DEPTH_P-1:0]     req    [NUM_FU_P];
  logic [DEPTH_P-1:0]     agrant [NUM_FU_P];
  logic [NUM_FU_P-1:0]    avalid;
  logic [DEPTH_P-1:0]     grant  [NUM_FU_P];
  logic [IDX_W-1:0]       gidx   [NUM_FU_P];
  logic [DEPTH_P-1:0]     issued;
  logic [IDX_W:0]         n_iss;

  // Backpressure looks only at the registered count.
  assign in_ready_o = rdy_en_q &
    (cnt_q != (IDX_W+1)'(DEPTH_P));
  assign accept  = in_valid_i & in_ready_o & ~flush_i;
  assign count_o = cnt_q;

  always_comb begin
    alloc_idx = '0;
    for (int e = DEPTH_P - 1; e >= 0; e--)
      if (state_q[e] == IQ_FREE)
        alloc_idx = IDX_W'(e);
  end

  always_comb begin
    d_meta.op        = instr_i.op;
    d_meta.dest      = instr_i.dest;
    d_meta.src1      = instr_i.src1;
    d_meta.src2      = instr_i.src2;
    d_meta.func_unit = instr_i.func_unit;
    d_meta.sb_idx    = instr_i.sb_idx;
    d_s1v = instr_i.src1_is_imm | src1_v_i;
    d_s2v = instr_i.src2_is_imm | src2_v_i;
    d_s1d = instr_i.src1_is_imm ?
            instr_i.imm : src1_data_i;
    d_s2d = instr_i.src2_is_imm ?
            instr_i.imm : src2_data_i;
    d_stv = ~instr_i.is_wfs;
    if (BYPASS_EN) begin
      for (int c = NUM_CDB_P - 1; c >= 0; c--) begin
        if (!instr_i.src1_is_imm && !src1_v_i &&
            cdb_i[c].valid &&
            cdb_i[c].tag == instr_i.src1) begin
          d_s1v = 1'b1;
          d_s1d = cdb_i[c].data;
        end
        if (!instr_i.src2_is_imm && !src2_v_i &&
            cdb_i[c].valid &&
            cdb_i[c].tag == instr_i.src2) begin
          d_s2v = 1'b1;
          d_s2d = cdb_i[c].data;
        end
      end
    end
  end

  // Descending scan leaves the lowest matching channel in place.
  always_comb begin
    for (int e = 0; e < DEPTH_P; e++) begin
      cap1[e]   = 1'b0;
      cap2[e]   = 1'b0;
      cap1_d[e] = '0;
      cap2_d[e] = '0;
      for (int c = NUM_CDB_P - 1; c >= 0; c--) begin
        if (cdb_i[c].valid &&
            cdb_i[c].tag == meta_q[e].src1) begin
          cap1[e]   = 1'b1;
          cap1_d[e] = cdb_i[c].data;
        end
        if (cdb_i[c].valid &&
            cdb_i[c].tag == meta_q[e].src2) begin
          cap2[e]   = 1'b1;
          cap2_d[e] = cdb_i[c].data;
        end
      end
      n1v[e]  = s1v_q[e] | cap1[e];
      n2v[e]  = s2v_q[e] | cap2[e];
      nstv[e] = stv_q[e] | st_clear_i[e];
    end
  end

  always_comb begin
    for (int f = 0; f < NUM_FU_P; f++) begin
      req[f] = '0;
      for (int e = 0; e < DEPTH_P; e++)
        req[f][e] = (state_q[e] == IQ_READY) &&
          (meta_q[e].func_unit == FU_W'(f));
    end
  end

  for (genvar f = 0; f < NUM_FU_P; f++) begin : g_sel
    iq_age_select #(
      .N     (DEPTH_P),
      .SEQ_W (SEQ_W)
    ) u_sel (
      .req_i   (req[f]),
      .seq_i   (seq_q),
      .grant_o (agrant[f]),
      .valid_o (avalid[f])
    );
  end

  // A stalled grant is pinned so a late wakeup cannot displace it.
  always_comb begin
    issued = '0;
    n_iss  = '0;
    for (int f = 0; f < NUM_FU_P; f++) begin
      grant[f] = lock_q[f] ?
        (DEPTH_P'(1) << lock_idx_q[f]) : agrant[f];
      issue_valid_o[f] =
        (lock_q[f] | avalid[f]) & ~flush_i;
      gidx[f] = '0;
      for (int e = 0; e < DEPTH_P; e++)
        if (grant[f][e])
          gidx[f] = IDX_W'(e);
      issue_o[f].op        = meta_q[gidx[f]].op;
      issue_o[f].dest      = meta_q[gidx[f]].dest;
      issue_o[f].src1_data = s1d_q[gidx[f]];
      issue_o[f].src2_data = s2d_q[gidx[f]];
      issue_o[f].sb_idx    = meta_q[gidx[f]].sb_idx;
      if (issue_valid_o[f] && issue_ready_i[f]) begin
        issued = issued | grant[f];
        n_iss  = n_iss + 1'b1;
      end
    end
  end

  always_comb begin
    for (int e = 0; e < DEPTH_P; e++)
      entry_sb_o[e] = meta_q[e].sb_idx;
  end

  always_ff @(posedge clk_i or negedge reset_ni) begin
    if (!reset_ni) begin
      cnt_q     <= '0;
      seq_ctr_q <= '0;
      rdy_en_q  <= 1'b0;
      s1v_q     <= '0;
      s2v_q     <= '0;
      stv_q     <= '0;
      lock_q    <= '0;
      for (int e = 0; e < DEPTH_P; e++) begin
        state_q[e] <= IQ_FREE;
        meta_q[e]  <= '0;
        s1d_q[e]   <= '0;
        s2d_q[e]   <= '0;
        seq_q[e]   <= '0;
      end
      for (int f = 0; f < NUM_FU_P; f++)
        lock_idx_q[f] <= '0;
    end else if (flush_i) begin
      cnt_q    <= '0;
      rdy_en_q <= 1'b1;
      s1v_q    <= '0;
      s2v_q    <= '0;
      stv_q    <= '0;
      lock_q   <= '0;
      for (int e = 0; e < DEPTH_P; e++)
        state_q[e] <= IQ_FREE;
    end else begin
      rdy_en_q <= 1'b1;
      cnt_q <= cnt_q +
        {{IDX_W{1'b0}}, accept} - n_iss;
      if (accept)
        seq_ctr_q <= seq_ctr_q + 1'b1;
      for (int e = 0; e < DEPTH_P; e++) begin
        if (accept && alloc_idx == IDX_W'(e)) begin
          state_q[e] <= (d_s1v && d_s2v && d_stv) ?
                        IQ_READY : IQ_WAIT;
          meta_q[e] <= d_meta;
          s1v_q[e]  <= d_s1v;
          s2v_q[e]  <= d_s2v;
          stv_q[e]  <= d_stv;
          s1d_q[e]  <= d_s1d;
          s2d_q[e]  <= d_s2d;
          seq_q[e]  <= seq_ctr_q;
        end else if (issued[e]) begin
          state_q[e] <= IQ_FREE;
        end else if (state_q[e] == IQ_WAIT) begin
          if (!s1v_q[e] && cap1[e]) begin
            s1v_q[e] <= 1'b1;
            s1d_q[e] <= cap1_d[e];
          end
          if (!s2v_q[e] && cap2[e]) begin
            s2v_q[e] <= 1'b1;
            s2d_q[e] <= cap2_d[e];
          end
          stv_q[e] <= nstv[e];
          if (n1v[e] && n2v[e] && nstv[e])
            state_q[e] <= IQ_READY;
        end
      end
      for (int f = 0; f < NUM_FU_P; f++) begin
        lock_q[f]     <= issue_valid_o[f] &
                         ~issue_ready_i[f];
        lock_idx_q[f] <= gidx[f];
      end
    end
  end

endmodule

// File: tb/tb_issue_queue_mw.sv
// Directed bench for issue_queue_mw: vector table plus corner sequences.
module tb_issue_queue_mw;
  import Purple_Jade_pkg::*;

  logic                   clk;
  logic                   reset_ni;
  renamed_instruction_t   instr_i;
  logic                   src1_v_i, src2_v_i;
  logic [WORD_SIZE_P-1:0] src1_data_i, src2_data_i;
  logic                   in_valid_i, in_ready_o;
  issued_instruction_t    issue_o [4];
  logic [3:0]             issue_valid_o, issue_ready_i;
  CDB_t                   cdb_i [4];
  logic [15:0]            st_clear_i;
  logic [SB_W-1:0]        entry_sb_o [16];
  logic                   flush_i;
  logic [4:0]             count_o;

  int n_chk = 0;
  int n_fail = 0;

  issue_queue_mw #(
    .DEPTH_P(16), .NUM_FU_P(4), .NUM_CDB_P(4)
  ) dut (
    .clk_i(clk), .reset_ni(reset_ni),
    .instr_i(instr_i),
    .src1_v_i(src1_v_i), .src2_v_i(src2_v_i),
    .src1_data_i(src1_data_i),
    .src2_data_i(src2_data_i),
    .in_valid_i(in_valid_i), .in_ready_o(in_ready_o),
    .issue_o(issue_o), .issue_valid_o(issue_valid_o),
    .issue_ready_i(issue_ready_i),
    .cdb_i(cdb_i), .st_clear_i(st_clear_i),
    .entry_sb_o(entry_sb_o), .flush_i(flush_i),
    .count_o(count_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit hit");
    $fatal(1);
  end

  task automatic chk(input string nm,
                     input logic [63:0] act,
                     input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h",
               nm, act, exp);
    end
  endtask

  function automatic renamed_instruction_t mk(
    input logic [7:0] op, input logic [1:0] fu,
    input logic [5:0] s1, input logic [5:0] s2,
    input logic wfs, input logic [2:0] sb);
    renamed_instruction_t r;
    r = '0;
    r.op = op; r.dest = op[5:0];
    r.src1 = s1; r.src2 = s2;
    r.func_unit = fu; r.is_wfs = wfs;
    r.sb_idx = sb;
    return r;
  endfunction

  task automatic disp(input renamed_instruction_t ins,
                      input logic v1, input logic [31:0] d1,
                      input logic v2, input logic [31:0] d2);
    instr_i = ins;
    src1_v_i = v1; src1_data_i = d1;
    src2_v_i = v2; src2_data_i = d2;
    in_valid_i = 1'b1;
  endtask

  task automatic clr_cdb();
    for (int c = 0; c < 4; c++) cdb_i[c] = '0;
  endtask

  typedef struct {
    logic [1:0]  fu;
    logic [7:0]  op;
    logic        i1, i2;
    logic [31:0] imm, d1, d2, e1, e2;
  } vec_t;

  vec_t vt [5];
  renamed_instruction_t ri;

  initial begin
    vt[0] = '{2'd0, 8'h01, 1'b0, 1'b0, 32'h0,
              32'h10, 32'h20, 32'h10, 32'h20};
    vt[1] = '{2'd1, 8'h02, 1'b1, 1'b0, 32'h55,
              32'hDEAD, 32'h7, 32'h55, 32'h7};
    vt[2] = '{2'd2, 8'h03, 1'b0, 1'b1, 32'hFFFF_FFFF,
              32'h1, 32'hDEAD, 32'h1, 32'hFFFF_FFFF};
    vt[3] = '{2'd3, 8'h04, 1'b1, 1'b1, 32'h0,
              32'h99, 32'h98, 32'h0, 32'h0};
    vt[4] = '{2'd0, 8'h05, 1'b0, 1'b0, 32'h0,
              32'hCAFE, 32'hF00D, 32'hCAFE, 32'hF00D};

    reset_ni = 1'b0;
    instr_i = '0; src1_v_i = 0; src2_v_i = 0;
    src1_data_i = '0; src2_data_i = '0;
    in_valid_i = 0; issue_ready_i = 4'hF;
    st_clear_i = '0; flush_i = 0;
    clr_cdb();
    #2;
    chk("rst_count", 64'(count_o), 0);
    chk("rst_in_ready", 64'(in_ready_o), 0);
    chk("rst_issue_valid", 64'(issue_valid_o), 0);
    chk("rst_entry_sb", 64'(entry_sb_o[0]), 0);
    repeat (2) @(negedge clk);
    reset_ni = 1'b1;
    #1 chk("rdy_before_edge", 64'(in_ready_o), 0);
    @(negedge clk);
    #1 chk("rdy_after_edge", 64'(in_ready_o), 1);

    // table: one fully-ready dispatch per vector
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      ri = mk(vt[i].op, vt[i].fu, 6'd1, 6'd2, 1'b0, 3'd0);
      ri.src1_is_imm = vt[i].i1;
      ri.src2_is_imm = vt[i].i2;
      ri.imm = vt[i].imm;
      disp(ri, ~vt[i].i1, vt[i].d1, ~vt[i].i2, vt[i].d2);
      #1 chk("vec_no_same_cycle", 64'(issue_valid_o), 0);
      @(negedge clk);
      in_valid_i = 0;
      #1;
      chk("vec_valid", 64'(issue_valid_o),
          64'(4'b1 << vt[i].fu));
      chk("vec_op", 64'(issue_o[vt[i].fu].op),
          64'(vt[i].op));
      chk("vec_src1", 64'(issue_o[vt[i].fu].src1_data),
          64'(vt[i].e1));
      chk("vec_src2", 64'(issue_o[vt[i].fu].src2_data),
          64'(vt[i].e2));
      chk("vec_count1", 64'(count_o), 1);
      @(negedge clk);
      #1 chk("vec_count0", 64'(count_o), 0);
    end

    // fill all entries waiting on tag 7
    for (int i = 0; i < 16; i++) begin
      @(negedge clk);
      disp(mk(8'(i), 2'(i % 4), 6'd7, 6'd2, 1'b0, 3'd0),
           1'b0, 32'h0, 1'b1, 32'(i));
      #1 chk("fill_no_issue", 64'(issue_valid_o), 0);
    end
    @(negedge clk);
    disp(mk(8'h77, 2'd0, 6'd1, 6'd2, 1'b0, 3'd0),
         1'b1, 32'h1, 1'b1, 32'h2);
    #1;
    chk("full_count", 64'(count_o), 16);
    chk("full_not_ready", 64'(in_ready_o), 0);
    @(negedge clk);
    in_valid_i = 0;
    cdb_i[0] = '{1'b1, 6'd7, 32'h0000_BEEF};
    cdb_i[3] = '{1'b1, 6'd7, 32'h0000_1111};
    #1 chk("full_blocked", 64'(count_o), 16);
    @(negedge clk);
    clr_cdb();
    for (int r = 0; r < 4; r++) begin
      #1;
      chk("wake_valid", 64'(issue_valid_o), 64'hF);
      chk("wake_count", 64'(count_o), 64'(16 - 4 * r));
      for (int f = 0; f < 4; f++) begin
        chk("wake_src1", 64'(issue_o[f].src1_data),
            64'h0000_BEEF);
        chk("wake_order", 64'(issue_o[f].src2_data),
            64'(r * 4 + f));
      end
      @(negedge clk);
    end
    #1 chk("wake_drained", 64'(count_o), 0);

    // FU0 stalled three cycles, FU1 keeps issuing
    issue_ready_i = 4'b1110;
    disp(mk(8'hA0, 2'd0, 6'd1, 6'd2, 1'b0, 3'd0),
         1'b1, 32'h11, 1'b1, 32'h0);
    @(negedge clk);
    disp(mk(8'hB0, 2'd0, 6'd1, 6'd2, 1'b0, 3'd0),
         1'b1, 32'h22, 1'b1, 32'h0);
    #1 chk("hold_c1", 64'(issue_o[0].src1_data), 64'h11);
    chk("hold_c1_valid", 64'(issue_valid_o[0]), 1);
    @(negedge clk);
    disp(mk(8'hC0, 2'd1, 6'd1, 6'd2, 1'b0, 3'd0),
         1'b1, 32'h33, 1'b1, 32'h0);
    #1 chk("hold_c2", 64'(issue_o[0].src1_data), 64'h11);
    @(negedge clk);
    in_valid_i = 0;
    #1 chk("hold_c3", 64'(issue_o[0].src1_data), 64'h11);
    chk("hold_fu1_valid", 64'(issue_valid_o[1]), 1);
    chk("hold_fu1_data", 64'(issue_o[1].src1_data), 64'h33);
    @(negedge clk);
    issue_ready_i = 4'hF;
    #1 chk("hold_release", 64'(issue_o[0].src1_data), 64'h11);
    chk("hold_count", 64'(count_o), 2);
    @(negedge clk);
    #1 chk("hold_next", 64'(issue_o[0].src1_data), 64'h22);
    @(negedge clk);
    #1 chk("hold_drained", 64'(count_o), 0);

    // wait-for-store entry
    @(negedge clk);
    disp(mk(8'hD0, 2'd2, 6'd1, 6'd2, 1'b1, 3'd5),
         1'b1, 32'h5, 1'b1, 32'h6);
    @(negedge clk);
    in_valid_i = 0;
    #1 chk("wfs_sb", 64'(entry_sb_o[0]), 5);
    chk("wfs_blocked0", 64'(issue_valid_o[2]), 0);
    @(negedge clk);
    #1 chk("wfs_blocked1", 64'(issue_valid_o[2]), 0);
    @(negedge clk);
    st_clear_i = 16'h0001;
    #1 chk("wfs_clear_cycle", 64'(issue_valid_o[2]), 0);
    @(negedge clk);
    st_clear_i = '0;
    #1 chk("wfs_issue", 64'(issue_valid_o[2]), 1);
    @(negedge clk);
    #1 chk("wfs_drained", 64'(count_o), 0);

    // flush with five parked entries
    issue_ready_i = 4'b0111;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      disp(mk(8'(8'hE0 + i), 2'd3, 6'd1, 6'd2, 1'b0, 3'd1),
           1'b1, 32'(i), 1'b1, 32'h0);
    end
    @(negedge clk);
    in_valid_i = 0;
    #1 chk("flush_pre_count", 64'(count_o), 5);
    chk("flush_pre_valid", 64'(issue_valid_o[3]), 1);
    @(negedge clk);
    flush_i = 1;
    disp(mk(8'hEF, 2'd0, 6'd1, 6'd2, 1'b0, 3'd0),
         1'b1, 32'h0, 1'b1, 32'h0);
    #1 chk("flush_valid", 64'(issue_valid_o), 0);
    @(negedge clk);
    flush_i = 0; in_valid_i = 0;
    #1 chk("flush_count", 64'(count_o), 0);
    chk("flush_ready", 64'(in_ready_o), 1);
    chk("flush_valid_after", 64'(issue_valid_o), 0);
    issue_ready_i = 4'hF;

    // age order with an older entry at a higher index,
    // across sequence-tag wrap
    @(negedge clk);
    disp(mk(8'h90, 2'd1, 6'd1, 6'd2, 1'b0, 3'd0),
         1'b1, 32'h0, 1'b1, 32'h0);
    @(negedge clk);
    disp(mk(8'h91, 2'd0, 6'd9, 6'd2, 1'b0, 3'd0),
         1'b0, 32'h0, 1'b1, 32'hB);
    @(negedge clk);
    disp(mk(8'h92, 2'd0, 6'd9, 6'd2, 1'b0, 3'd0),
         1'b0, 32'h0, 1'b1, 32'hC);
    @(negedge clk);
    in_valid_i = 0;
    cdb_i[0] = '{1'b1, 6'd9, 32'h99};
    #1 chk("age_wait", 64'(issue_valid_o), 0);
    @(negedge clk);
    clr_cdb();
    #1 chk("age_first_valid", 64'(issue_valid_o[0]), 1);
    chk("age_first", 64'(issue_o[0].src2_data), 64'hB);
    @(negedge clk);
    #1 chk("age_second", 64'(issue_o[0].src2_data), 64'hC);
    @(negedge clk);
    #1 chk("age_drained", 64'(count_o), 0);

    // reset dropped mid-stream
    issue_ready_i = 4'b0111;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      disp(mk(8'(8'h60 + i), 2'd3, 6'd1, 6'd2, 1'b0, 3'd3),
           1'b1, 32'h0, 1'b1, 32'h0);
    end
    @(negedge clk);
    in_valid_i = 0;
    #1 chk("rst2_pre_count", 64'(count_o), 3);
    chk("rst2_pre_sb", 64'(entry_sb_o[0]), 3);
    reset_ni = 0;
    #1 chk("rst2_count", 64'(count_o), 0);
    chk("rst2_valid", 64'(issue_valid_o), 0);
    chk("rst2_ready", 64'(in_ready_o), 0);
    chk("rst2_sb", 64'(entry_sb_o[0]), 0);
    @(negedge clk);
    reset_ni = 1;
    issue_ready_i = 4'hF;
    @(negedge clk);
    #1 chk("rst2_ready_up", 64'(in_ready_o), 1);
    chk("rst2_count_after", 64'(count_o), 0);

    // CDB broadcast in the dispatch cycle of a consumer
    @(negedge clk);
    disp(mk(8'h30, 2'd0, 6'd3, 6'd2, 1'b0, 3'd0),
         1'b0, 32'h0, 1'b1, 32'h9);
    cdb_i[1] = '{1'b1, 6'd3, 32'h1234};
    @(negedge clk);
    in_valid_i = 0;
    clr_cdb();
`ifdef ISSUE_DISPATCH_BYPASS_EN
    #1 chk("byp_issue", 64'(issue_valid_o[0]), 1);
    chk("byp_data", 64'(issue_o[0].src1_data), 64'h1234);
    @(negedge clk);
    #1 chk("byp_drained", 64'(count_o), 0);
`else
    #1 chk("nobyp_wait0", 64'(issue_valid_o[0]), 0);
    @(negedge clk);
    #1 chk("nobyp_wait1", 64'(issue_valid_o[0]), 0);
    chk("nobyp_count", 64'(count_o), 1);
    cdb_i[2] = '{1'b1, 6'd3, 32'hAAAA};
    cdb_i[1] = '{1'b1, 6'd3, 32'h5678};
    @(negedge clk);
    clr_cdb();
    #1 chk("cdb_low_valid", 64'(issue_valid_o[0]), 1);
    chk("cdb_low_chan", 64'(issue_o[0].src1_data), 64'h5678);
    @(negedge clk);
    #1 chk("cdb_drained", 64'(count_o), 0);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
